// File: rtl/mux_rr_n.sv
// N-channel, WIDTH-bit stream multiplexer with a single registered output stage.
// Channel choice is wrap-around round-robin among valid inputs, or an external select.
module mux_rr_n #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    input  logic                    manual_en,
    input  logic [CH_W-1:0]         manual_sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [CH_W-1:0]         out_ch,
    input  logic                    out_ready
);

    logic [CH_W-1:0]  rr_ptr;
    logic [N_CH-1:0]  sel_oh;
    logic [N_CH-1:0]  elig;
    logic [N_CH-1:0]  grant;
    logic [CH_W-1:0]  grant_idx;
    logic [CH_W-1:0]  ptr_next;
    logic [WIDTH-1:0] sel_data;
    logic             found;
    logic             load;
    logic             xfer;
    int unsigned      idx;

    assign load     = ~out_valid | out_ready;
    assign in_ready = grant & {N_CH{load}};
    assign xfer     = load & found;

    // An out-of-range manual_sel matches no channel, so nothing becomes eligible.
    always_comb begin
        sel_oh = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            sel_oh[i] = (32'(manual_sel) == i);
        end
        elig = manual_en ? (in_valid & sel_oh) : in_valid;
    end

    // Scan starting at rr_ptr with wrap-around; the first eligible channel wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = (32'(rr_ptr) + k) % N_CH;
            if (!found && elig[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = CH_W'(idx);
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
        ptr_next = CH_W'((32'(grant_idx) + 1) % N_CH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_ch    <= grant_idx;
                if (!manual_en) begin
                    rr_ptr <= ptr_next;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed bench for mux_rr_n: a vector table stepped one clock per row,
// plus hand sequences for asynchronous reset and an out-of-range manual select.
module tb_mux_rr_n;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        manual_en;
    logic [1:0]  manual_sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic        out_ready;

    logic [39:0] in_data5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_ready5;
    logic        manual_en5;
    logic [2:0]  manual_sel5;
    logic [7:0]  out_data5;
    logic        out_valid5;
    logic [2:0]  out_ch5;
    logic        out_ready5;

    int errors = 0;
    int checks = 0;

    mux_rr_n #(.N_CH(4), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .manual_en(manual_en), .manual_sel(manual_sel),
        .out_data(out_data), .out_valid(out_valid), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    mux_rr_n #(.N_CH(5), .WIDTH(8)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
        .manual_en(manual_en5), .manual_sel(manual_sel5),
        .out_data(out_data5), .out_valid(out_valid5), .out_ch(out_ch5),
        .out_ready(out_ready5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  iv;
        logic        me;
        logic [1:0]  ms;
        logic        ord;
        logic [31:0] dat;
        logic [3:0]  rdy;
        logic        ov;
        logic [1:0]  ch;
        logic [7:0]  od;
    } vec_t;

    vec_t vt[$];

    localparam logic [31:0] D0 = 32'h13121110;
    localparam logic [31:0] DA = 32'h131211A5;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] iv, input logic me, input logic [1:0] ms,
                       input logic ord, input logic [31:0] dat, input logic [3:0] rdy,
                       input logic ov, input logic [1:0] ch, input logic [7:0] od);
        vec_t v;
        v.iv = iv; v.me = me; v.ms = ms; v.ord = ord; v.dat = dat;
        v.rdy = rdy; v.ov = ov; v.ch = ch; v.od = od;
        vt.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; in_data = D0; in_valid = '0; manual_en = 1'b0; manual_sel = '0;
        out_ready = 1'b1;
        in_data5 = 40'h1413121110; in_valid5 = '0; manual_en5 = 1'b0; manual_sel5 = '0;
        out_ready5 = 1'b1;

        // full-rate round-robin: 0,1,2,3,0,1,2,3
        add(4'hF, 0, 0, 1, D0, 4'b0001, 1, 0, 8'h10);
        add(4'hF, 0, 0, 1, D0, 4'b0010, 1, 1, 8'h11);
        add(4'hF, 0, 0, 1, D0, 4'b0100, 1, 2, 8'h12);
        add(4'hF, 0, 0, 1, D0, 4'b1000, 1, 3, 8'h13);
        add(4'hF, 0, 0, 1, D0, 4'b0001, 1, 0, 8'h10);
        add(4'hF, 0, 0, 1, D0, 4'b0010, 1, 1, 8'h11);
        add(4'hF, 0, 0, 1, D0, 4'b0100, 1, 2, 8'h12);
        add(4'hF, 0, 0, 1, D0, 4'b1000, 1, 3, 8'h13);
        // sparse with wrap: 0,3,0,3
        add(4'b1001, 0, 0, 1, D0, 4'b0001, 1, 0, 8'h10);
        add(4'b1001, 0, 0, 1, D0, 4'b1000, 1, 3, 8'h13);
        add(4'b1001, 0, 0, 1, D0, 4'b0001, 1, 0, 8'h10);
        add(4'b1001, 0, 0, 1, D0, 4'b1000, 1, 3, 8'h13);
        // load 0xA5, stall 3 cycles, then release
        add(4'b0001, 0, 0, 1, DA, 4'b0001, 1, 0, 8'hA5);
        add(4'b0010, 0, 0, 0, DA, 4'b0000, 1, 0, 8'hA5);
        add(4'b0010, 0, 0, 0, DA, 4'b0000, 1, 0, 8'hA5);
        add(4'b0010, 0, 0, 0, DA, 4'b0000, 1, 0, 8'hA5);
        add(4'b0010, 0, 0, 1, DA, 4'b0010, 1, 1, 8'h11);
        // manual ch2 twice (pointer stays 2), then manual with ch0 not valid drains
        add(4'hF,    1, 2, 1, D0, 4'b0100, 1, 2, 8'h12);
        add(4'hF,    1, 2, 1, D0, 4'b0100, 1, 2, 8'h12);
        add(4'b1110, 1, 0, 1, D0, 4'b0000, 0, 2, 8'h12);
        // back to round-robin: resumes at pre-manual pointer 2
        add(4'hF,    0, 0, 1, D0, 4'b0100, 1, 2, 8'h12);
        add(4'hF,    0, 0, 1, D0, 4'b1000, 1, 3, 8'h13);
        // mode switch during a stall keeps the held beat
        add(4'hF,    1, 1, 0, D0, 4'b0000, 1, 3, 8'h13);
        add(4'hF,    1, 1, 1, D0, 4'b0010, 1, 1, 8'h11);
        add(4'b0000, 0, 0, 1, D0, 4'b0000, 0, 1, 8'h11);

        #2;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_ch", out_ch, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[r]) begin
            @(negedge clk);
            in_valid = vt[r].iv; manual_en = vt[r].me; manual_sel = vt[r].ms;
            out_ready = vt[r].ord; in_data = vt[r].dat;
            #1;
            chk($sformatf("row%0d_in_ready", r), in_ready, vt[r].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_out_valid", r), out_valid, vt[r].ov);
            chk($sformatf("row%0d_out_ch", r), out_ch, vt[r].ch);
            chk($sformatf("row%0d_out_data", r), out_data, vt[r].od);
        end

        // async reset while a beat is held; pointer at 3 before reset
        @(negedge clk);
        in_valid = 4'b0100; manual_en = 1'b0; out_ready = 1'b0; in_data = D0;
        @(posedge clk);
        #1;
        chk("pre_reset_out_valid", out_valid, 1);
        chk("pre_reset_out_ch", out_ch, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", out_valid, 0);
        chk("async_reset_out_data", out_data, 0);
        chk("async_reset_out_ch", out_ch, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 4'hF; out_ready = 1'b1;
        #1;
        chk("post_reset_in_ready", in_ready, 4'b0001);
        @(posedge clk);
        #1;
        chk("post_reset_out_ch", out_ch, 0);
        chk("post_reset_out_data", out_data, 8'h10);

        // N_CH=5: valid select 4, then out-of-range select 7
        @(negedge clk);
        in_valid = '0;
        in_valid5 = 5'b11111; manual_en5 = 1'b1; manual_sel5 = 3'd4;
        #1;
        chk("n5_sel4_in_ready", in_ready5, 5'b10000);
        @(posedge clk);
        #1;
        chk("n5_sel4_out_valid", out_valid5, 1);
        chk("n5_sel4_out_ch", out_ch5, 4);
        chk("n5_sel4_out_data", out_data5, 8'h14);
        @(negedge clk);
        manual_sel5 = 3'd7;
        #1;
        chk("n5_sel7_in_ready", in_ready5, 5'b00000);
        @(posedge clk);
        #1;
        chk("n5_sel7_out_valid", out_valid5, 0);
        chk("n5_sel7_out_ch_hold", out_ch5, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_rr_n.md
Name: mux_rr_n

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with one registered output stage and valid/ready handshakes on every port.
- Successor to the 2:1 combinational mux.
- Selection is either round-robin arbitration among valid channels or manual, steered by an external select.
- Sits between several producer streams and one consumer.

Parameters:
- N_CH, 4, number of input channels (≥2).
- WIDTH, 8, data width per channel.
- CH_W, $clog2(N_CH), width of channel index (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready (combinational).
- manual_en  input  1  1 = manual select mode, 0 = round-robin.
- manual_sel  input  CH_W  channel index used when manual_en=1.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ch  output  CH_W  registered index of the channel that produced out_data.
- out_ready  input  1  consumer ready.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. Assertion immediately clears out_valid=0, out_data=0, out_ch=0, rr_ptr=0; release is synchronous to clk.
- Load enable: load = ~out_valid | out_ready. The output register accepts a new beat only when load=1.
- Eligibility:
  - Round-robin: elig = in_valid.
  - Manual: elig = in_valid & onehot(manual_sel). If manual_sel ≥ N_CH, elig = 0 and nothing is granted.
- Round-robin grant: the first eligible channel scanning rr_ptr, rr_ptr+1, …, N_CH-1, 0, …, rr_ptr-1 (wrap-around). At most one grant bit is set. No grant when elig = 0.
- Ready: in_ready[i] = grant[i] & load. It is combinational from in_valid, manual_*, out_valid, out_ready and rr_ptr. in_ready never depends on in_data.
- Transfer: a channel-i transfer occurs when in_valid[i] & in_ready[i]. On that clk edge: out_data <= channel i data, out_ch <= i, out_valid <= 1.
- Pointer update: if a transfer occurs and manual_en=0, rr_ptr <= (i+1) mod N_CH. In manual mode rr_ptr holds.
- Drain: if load=1 and no transfer, out_valid <= 0. out_data and out_ch hold their last values.
- Stall: out_valid=1 & out_ready=0 → all in_ready=0; out_data, out_ch, out_valid and rr_ptr hold stable.
- Throughput and latency: one beat per cycle at full rate (back-to-back when out_ready held 1). Input-to-output latency is 1 cycle.
- Fairness: with all channels continuously valid in round-robin mode, grants cycle 0,1,…,N_CH-1,0,…. No channel waits more than N_CH-1 transfers.
- Mode switch: takes effect the same cycle, since grant is combinational. A switch mid-stall does not disturb the held output beat.
- Input protocol: inputs must hold in_valid and in_data until accepted. The block does not check this.
- Reset mid-operation: a held output beat is discarded (out_valid drops asynchronously), and arbitration restarts at channel 0.

Test Plan:
- Reset: rst_n=0 while out_valid=1 (asserted off-edge) → out_valid=0, out_data=0, out_ch=0 immediately. After release, all valid with data 0x10,0x11,0x12,0x13 → first beat out_ch=0, out_data=0x10.
- Full-rate round-robin: N_CH=4, in_valid=4'b1111, out_ready=1, 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3, one beat per cycle, each in_ready pulse one-hot.
- Sparse round-robin with wrap: in_valid=4'b1001 constant, rr_ptr starts 0 → out_ch 0,3,0,3; channels 1 and 2 never granted, in_ready[2:1]=0.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1, out_data=0xA5 → out_data/out_ch stable, in_ready=0. Raise out_ready → next beat loads the same cycle, no beat lost or duplicated.
- Manual mode: manual_en=1, manual_sel=2, in_valid=4'b1111 → only in_ready[2] pulses, out_ch=2 every beat. manual_sel=3'd? ≥N_CH (use N_CH=5, sel=7) → in_ready=0, out_valid drops after drain.
- Mode return: after manual transfers on ch2, set manual_en=0 → rr_ptr unchanged by manual beats, so the next grant resumes from the pre-manual pointer.
